// File: rtl/uart_pkg.sv
// Shared definitions for the UART client blocks: ASCII codes, message
// lengths and the time-sender state encoding.
package uart_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;

    localparam int MSG_LEN_CRLF = 10;
    localparam int MSG_LEN_BARE = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } tx_state_e;

    // Index of the final byte of a message, as a 4-bit byte index.
    function automatic logic [3:0] msg_last_idx(input bit with_crlf);
        return with_crlf ? 4'(MSG_LEN_CRLF - 1) : 4'(MSG_LEN_BARE - 1);
    endfunction

endpackage

// File: rtl/uart_time_sender_bin2ascii2.sv
// Two-digit decimal ASCII encoder for a 6-bit binary value (0..63).
// Values above 59 are encoded literally; no clamping.
module bin2ascii2
    import uart_pkg::*;
(
    input  logic [5:0] bin_i,
    output logic [7:0] tens_o,
    output logic [7:0] ones_o
);

    logic [5:0] tens_v;
    logic [5:0] ones_v;

    // Constant-divisor split into decimal digits.
    always_comb begin
        tens_v = bin_i / 6'd10;
        ones_v = bin_i - (tens_v * 6'd10);
        tens_o = ASCII_ZERO + {2'b00, tens_v};
        ones_o = ASCII_ZERO + {2'b00, ones_v};
    end

endmodule

// File: rtl/uart_time_sender.sv
// Sends a frozen snapshot of the watch time as "HH:MM:SS" (optionally
// followed by CR LF) through the uart_controller byte handshake.
//
// state  | meaning
// IDLE   | waiting for send_req; snapshot captured on acceptance
// SEND   | byte idx ready; launches it once the transmitter is free
// WAIT   | byte launched; waiting for the transmitter's tx_done
// FINISH | last byte done; pulses done and releases busy
module uart_time_sender
    import uart_pkg::*;
#(
    parameter bit         SEND_CRLF = 1'b1,
    parameter logic [7:0] SEP_CHAR  = 8'h3A
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       send_req,
    input  logic [4:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_din,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LAST_IDX = msg_last_idx(SEND_CRLF);

    tx_state_e  state_q;
    logic [3:0] idx_q;
    logic [4:0] hour_q;
    logic [5:0] min_q;
    logic [5:0] sec_q;
    logic       tx_start_q;
    logic [7:0] tx_din_q;
    logic       busy_q;
    logic       done_q;

    logic [7:0] hour_tens, hour_ones;
    logic [7:0] min_tens,  min_ones;
    logic [7:0] sec_tens,  sec_ones;
    logic [7:0] tx_din_d;

    bin2ascii2 u_hour_enc (
        .bin_i  ({1'b0, hour_q}),
        .tens_o (hour_tens),
        .ones_o (hour_ones)
    );

    bin2ascii2 u_min_enc (
        .bin_i  (min_q),
        .tens_o (min_tens),
        .ones_o (min_ones)
    );

    bin2ascii2 u_sec_enc (
        .bin_i  (sec_q),
        .tens_o (sec_tens),
        .ones_o (sec_ones)
    );

    // Select the message byte at idx from the snapshot encodings.
    always_comb begin
        tx_din_d = 8'h00;
        case (idx_q)
            4'd0:    tx_din_d = hour_tens;
            4'd1:    tx_din_d = hour_ones;
            4'd2:    tx_din_d = SEP_CHAR;
            4'd3:    tx_din_d = min_tens;
            4'd4:    tx_din_d = min_ones;
            4'd5:    tx_din_d = SEP_CHAR;
            4'd6:    tx_din_d = sec_tens;
            4'd7:    tx_din_d = sec_ones;
            4'd8:    tx_din_d = ASCII_CR;
            4'd9:    tx_din_d = ASCII_LF;
            default: tx_din_d = 8'h00;
        endcase
    end

    // Message sequencer with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            hour_q     <= 5'd0;
            min_q      <= 6'd0;
            sec_q      <= 6'd0;
            tx_start_q <= 1'b0;
            tx_din_q   <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (send_req) begin
                        hour_q  <= i_hour;
                        min_q   <= i_min;
                        sec_q   <= i_sec;
                        idx_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_din_q   <= tx_din_d;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    // A done seen alongside our own launch strobe belongs to
                    // the previous byte, so it is discarded.
                    if (tx_done && !tx_start_q) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= FINISH;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= SEND;
                        end
                    end
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_start = tx_start_q;
    assign tx_din   = tx_din_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
